// File: rtl/stream_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stream_reg_pkg
// Brief    : Mode encodings and helpers shared by the stream pipeline register.
// Revision : 1.0
// ============================================================================
package stream_reg_pkg;

  localparam int MODE_FALL_THROUGH = 0;
  localparam int MODE_PIPE         = 1;
  localparam int MODE_SPILL        = 2;

  function automatic int occupancy_width();
    return 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_reg_slot.sv
`default_nettype none
// ============================================================================
// Module   : stream_reg_slot
// Brief    : One storage entry: data register plus full flag.
// Revision : 1.0
// ============================================================================
module stream_reg_slot #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  i_load,
  input  logic                  i_clear,
  input  logic                  i_flush,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_full
);

  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_full;

  // Load beats clear so a same-cycle pop+push keeps the slot full;
  // flush empties the slot but leaves the data register untouched.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_data <= '0;
      r_full <= 1'b0;
    end else begin
      if (i_flush) begin
        r_full <= 1'b0;
      end else if (i_load) begin
        r_full <= 1'b1;
      end else if (i_clear) begin
        r_full <= 1'b0;
      end
      if (i_load && !i_flush) begin
        r_data <= i_data;
      end
    end
  end

  assign o_data = r_data;
  assign o_full = r_full;

endmodule
`default_nettype wire

// File: rtl/stream_pipe_register.sv
`default_nettype none
// ============================================================================
// Module   : stream_pipe_register
// Brief    : Valid/ready pipeline register, fall-through / pipe / spill modes.
// Revision : 1.0
// ============================================================================
module stream_pipe_register
  import stream_reg_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MODE       = MODE_FALL_THROUGH
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           clr_i,
  input  logic                           valid_i,
  output logic                           ready_o,
  input  logic [DATA_WIDTH-1:0]          data_i,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [DATA_WIDTH-1:0]          data_o,
  output logic [occupancy_width()-1:0]   occupancy_o
);

  localparam int OCC_W = occupancy_width();

  // Handshakes are suppressed while resetting or flushing.
  logic w_block;
  assign w_block = rst_i | clr_i;

  if (DATA_WIDTH < 1) begin : g_bad_width
    $error("stream_pipe_register: DATA_WIDTH must be >= 1");
  end

  case (MODE)
    MODE_FALL_THROUGH: begin : g_fall_through
      logic                  w_full;
      logic [DATA_WIDTH-1:0] w_data;
      logic                  w_push;
      logic                  w_pop;

      assign ready_o     = ~w_full & ~w_block;
      assign valid_o     = (w_full | valid_i) & ~w_block;
      assign data_o      = w_full ? w_data : data_i;
      assign w_push      = valid_i & ready_o;
      assign w_pop       = valid_o & ready_i;
      assign occupancy_o = OCC_W'(w_full);

      stream_reg_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_load  (w_push & ~ready_i),
        .i_clear (w_pop & w_full),
        .i_flush (clr_i),
        .i_data  (data_i),
        .o_data  (w_data),
        .o_full  (w_full)
      );
    end

    MODE_PIPE: begin : g_pipe
      logic                  w_full;
      logic [DATA_WIDTH-1:0] w_data;
      logic                  w_push;
      logic                  w_pop;

      assign valid_o     = w_full & ~w_block;
      assign data_o      = w_data;
      assign ready_o     = (~w_full | ready_i) & ~w_block;
      assign w_push      = valid_i & ready_o;
      assign w_pop       = valid_o & ready_i;
      assign occupancy_o = OCC_W'(w_full);

      stream_reg_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_load  (w_push),
        .i_clear (w_pop),
        .i_flush (clr_i),
        .i_data  (data_i),
        .o_data  (w_data),
        .o_full  (w_full)
      );
    end

    MODE_SPILL: begin : g_spill
      logic                  w_a_full;
      logic                  w_b_full;
      logic [DATA_WIDTH-1:0] w_a_data;
      logic [DATA_WIDTH-1:0] w_b_data;
      logic                  w_push;
      logic                  w_pop;
      logic                  w_a_load;
      logic                  w_b_load;

      assign valid_o     = w_a_full & ~w_block;
      assign data_o      = w_a_data;
      assign ready_o     = ~w_b_full & ~w_block;
      assign w_push      = valid_i & ready_o;
      assign w_pop       = valid_o & ready_i;
      // A refills from B when B holds data; B is only empty-able via A.
      assign w_a_load    = (w_push & (~w_a_full | (w_pop & ~w_b_full))) | (w_pop & w_b_full);
      assign w_b_load    = w_push & w_a_full & ~w_pop;
      assign occupancy_o = OCC_W'(w_a_full) + OCC_W'(w_b_full);

      stream_reg_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot_a (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_load  (w_a_load),
        .i_clear (w_pop),
        .i_flush (clr_i),
        .i_data  (w_b_full ? w_b_data : data_i),
        .o_data  (w_a_data),
        .o_full  (w_a_full)
      );

      stream_reg_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot_b (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_load  (w_b_load),
        .i_clear (w_pop & w_b_full),
        .i_flush (clr_i),
        .i_data  (data_i),
        .o_data  (w_b_data),
        .o_full  (w_b_full)
      );
    end

    default: begin : g_bad_mode
      $error("stream_pipe_register: unsupported MODE %0d", MODE);
      assign valid_o     = 1'b0;
      assign ready_o     = 1'b0;
      assign data_o      = '0;
      assign occupancy_o = '0;
    end
  endcase

endmodule
`default_nettype wire

// File: tb/tb_stream_pipe_register.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_pipe_register
// Brief    : Scoreboard bench driving one instance of each mode in parallel.
// Revision : 1.0
// ============================================================================
module tb_stream_pipe_register;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic       v_in  [3];
  logic       r_in  [3];
  logic [7:0] d_in  [3];
  logic       v_out [3];
  logic       r_out [3];
  logic [7:0] d_out [3];
  logic [1:0] occ   [3];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    stream_pipe_register #(.DATA_WIDTH(8), .MODE(k)) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .clr_i       (clr),
      .valid_i     (v_in[k]),
      .ready_o     (r_out[k]),
      .data_i      (d_in[k]),
      .valid_o     (v_out[k]),
      .ready_i     (r_in[k]),
      .data_o      (d_out[k]),
      .occupancy_o (occ[k])
    );
  end

  int n_chk  = 0;
  int n_pass = 0;

  // Reference: contents of each register as a plain FIFO of accepted beats.
  logic [7:0] mq  [3][$];
  // Scoreboard: beats the model says must leave, in order.
  logic [7:0] sbq [3][$];
  logic       m_acc    [3];
  logic       hold_arm [3];
  logic [7:0] p_data   [3];
  logic       started = 1'b0;

  task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, k, act, exp, $time);
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      int         cnt;
      logic       ev, er, push, pop;
      if (rst) begin
        mq[k].delete();
        m_acc[k]    = 1'b0;
        hold_arm[k] = 1'b0;
        started     = 1'b1;
      end else if (started) begin
        cnt = mq[k].size();
        ev  = !clr && (cnt > 0 || (k == 0 && v_in[k]));
        case (k)
          0:       er = !clr && cnt == 0;
          1:       er = !clr && (cnt == 0 || r_in[k]);
          default: er = !clr && cnt < 2;
        endcase
        check("valid_o", k, 32'(v_out[k]), 32'(ev));
        check("ready_o", k, 32'(r_out[k]), 32'(er));
        check("occupancy_o", k, 32'(occ[k]), 32'(cnt));
        if (hold_arm[k] && !clr) begin
          n_chk++;
          assert (v_out[k] === 1'b1 && d_out[k] === p_data[k]) n_pass++;
          else $display("FAIL hold dut%0d: valid_o=%b data_o=%0h required valid_o=1 data_o=%0h",
                        k, v_out[k], d_out[k], p_data[k]);
        end
        push = v_in[k] && er;
        pop  = ev && r_in[k];
        if (push) mq[k].push_back(d_in[k]);
        if (ev) check("data_o", k, 32'(d_out[k]), 32'(mq[k][0]));
        if (pop) sbq[k].push_back(mq[k].pop_front());
        if (clr) mq[k].delete();
        m_acc[k]    = push;
        hold_arm[k] = v_out[k] && !r_in[k] && !clr;
        p_data[k]   = d_out[k];
      end
    end
  end

  // Monitor: every real output transfer must match the next predicted beat.
  always @(negedge clk) begin
    #2;
    for (int k = 0; k < 3; k++) begin
      logic [7:0] e;
      if (started && !rst && v_out[k] === 1'b1 && r_in[k]) begin
        check("sb_avail", k, 32'(sbq[k].size() != 0), 32'd1);
        if (sbq[k].size() != 0) begin
          e = sbq[k].pop_front();
          check("sb_data", k, 32'(d_out[k]), 32'(e));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic stream(input int k, input logic [7:0] first, input int n, input bit gap);
    int         sent = 0;
    int         cyc  = 0;
    logic [7:0] d    = first;
    v_in[k] = 1'b1;
    d_in[k] = d;
    while (sent < n && cyc < 200) begin
      r_in[k] = gap ? (cyc % 3 != 2) : 1'b1;
      tick();
      if (m_acc[k]) begin
        sent++;
        d++;
        d_in[k] = d;
      end
      cyc++;
    end
    v_in[k] = 1'b0;
    r_in[k] = 1'b1;
    check("stream_budget", k, 32'(sent), 32'(n));
  endtask

  initial begin
    int w;
    rst = 1'b1;
    clr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      v_in[k] = 1'b1;
      r_in[k] = 1'b0;
      d_in[k] = 8'h5A;
    end
    idle(2);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      v_in[k] = 1'b0;
      r_in[k] = 1'b1;
    end
    @(negedge clk);
    check("rst_valid", 2, 32'(v_out[2]), 32'd0);
    check("rst_ready", 2, 32'(r_out[2]), 32'd1);
    check("rst_occ", 2, 32'(occ[2]), 32'd0);

    // Fall-through bypass
    tick();
    v_in[0] = 1'b1; d_in[0] = 8'hA5; r_in[0] = 1'b1;
    @(negedge clk);
    check("ft_bypass_valid", 0, 32'(v_out[0]), 32'd1);
    check("ft_bypass_data", 0, 32'(d_out[0]), 32'hA5);
    check("ft_bypass_occ", 0, 32'(occ[0]), 32'd0);

    // Fall-through stall then release
    tick();
    d_in[0] = 8'h11; r_in[0] = 1'b0;
    tick();
    v_in[0] = 1'b0;
    @(negedge clk);
    check("ft_stall_ready", 0, 32'(r_out[0]), 32'd0);
    check("ft_stall_data", 0, 32'(d_out[0]), 32'h11);
    check("ft_stall_occ", 0, 32'(occ[0]), 32'd1);
    tick();
    r_in[0] = 1'b1;
    tick();
    @(negedge clk);
    check("ft_release_ready", 0, 32'(r_out[0]), 32'd1);
    check("ft_release_occ", 0, 32'(occ[0]), 32'd0);
    tick();

    // Pipe streaming, continuous then with periodic stalls
    stream(1, 8'h01, 16, 1'b0);
    idle(2);
    stream(1, 8'h01, 16, 1'b1);
    idle(3);

    // Spill fill and drain
    r_in[2] = 1'b0; v_in[2] = 1'b1; d_in[2] = 8'h22;
    tick();
    d_in[2] = 8'h33;
    tick();
    d_in[2] = 8'h44;
    tick();
    @(negedge clk);
    check("spill_full_ready", 2, 32'(r_out[2]), 32'd0);
    check("spill_full_occ", 2, 32'(occ[2]), 32'd2);
    tick();
    r_in[2] = 1'b1;
    w = 0;
    tick();
    while (!m_acc[2] && w < 10) begin
      tick();
      w++;
    end
    check("spill_44_accepted", 2, 32'(w < 10), 32'd1);
    v_in[2] = 1'b0;
    idle(4);

    // Clear mid-stream on every mode
    for (int k = 0; k < 3; k++) begin
      r_in[k] = 1'b0; v_in[k] = 1'b1; d_in[k] = 8'hC0 + 8'(k);
    end
    tick();
    for (int k = 0; k < 3; k++) d_in[k] = 8'hD0 + 8'(k);
    tick();
    clr = 1'b1;
    for (int k = 0; k < 3; k++) r_in[k] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("clr_valid", k, 32'(v_out[k]), 32'd0);
      check("clr_ready", k, 32'(r_out[k]), 32'd0);
    end
    tick();
    clr = 1'b0;
    for (int k = 0; k < 3; k++) v_in[k] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) check("post_clr_occ", k, 32'(occ[k]), 32'd0);
    idle(3);

    // Randomised traffic with occasional flushes
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 3; k++) begin
        v_in[k] = ($urandom % 4) != 0;
        r_in[k] = ($urandom % 3) != 0;
        d_in[k] = 8'($urandom);
      end
      clr = ($urandom % 40) == 0;
      tick();
    end
    clr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      v_in[k] = 1'b0;
      r_in[k] = 1'b1;
    end
    idle(6);
    for (int k = 0; k < 3; k++) begin
      check("drained_sb", k, 32'(sbq[k].size()), 32'd0);
      check("drained_occ", k, 32'(occ[k]), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
